// File: rtl/mem_controller.sv
// mem_controller: byte-serial RAM arbiter between instruction fetch (IF)
// and load/store buffer (LSB); reads gather bytes little-endian.
// Ports: Sys_clk/Sys_rst (sync, active-high), Sys_rdy (freeze when low),
//   IFMC_* fetch request, MCIF_* fetch done/data, LSBMC_* load/store request,
//   MCLSB_* load/store done/data, RoBMC_pre_judge (0 = flush),
//   mem_din/mem_dout/mem_a/mem_wr RAM port, io_buffer_full UART FIFO full.
// Optional macro MC_IO_STALL_EN: hold I/O store bytes while io_buffer_full.
module mem_controller #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_SEL     = 2'b11
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  IFMC_en,
  input  logic [ADDR_WIDTH-1:0] IFMC_addr,
  output logic                  MCIF_en,
  output logic [31:0]           MCIF_data,
  input  logic                  LSBMC_en,
  input  logic                  LSBMC_wr,
  input  logic [2:0]            LSBMC_data_width,
  input  logic [ADDR_WIDTH-1:0] LSBMC_addr,
  input  logic [31:0]           LSBMC_data,
  output logic                  MCLSB_r_en,
  output logic                  MCLSB_w_en,
  output logic [31:0]           MCLSB_data,
  input  logic                  RoBMC_pre_judge,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  state_t state_q, state_n;

  // last_q / cur_q: 1 = LSB, 0 = IF
  logic                  last_q, last_n;
  logic                  cur_q, cur_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [2:0]            width_q, width_n;
  logic [2:0]            cnt_q, cnt_n;
  logic [31:0]           data_q, data_n;
  logic [31:0]           buf_q, buf_n;

  logic                  mcif_en_q, mcif_en_n;
  logic [31:0]           mcif_data_q, mcif_data_n;
  logic                  r_en_q, r_en_n;
  logic                  w_en_q, w_en_n;
  logic [31:0]           lsb_data_q, lsb_data_n;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_n;
  logic [7:0]            dout_q, dout_n;
  logic                  wr_q, wr_n;

  logic                  flush;
  logic                  if_req;
  logic                  lsb_win;
  logic [ADDR_WIDTH-1:0] byte_a;
  logic [1:0]            bidx;
  logic [31:0]           buf_m;
  logic [7:0]            wr_byte;
  logic                  io_stall;

  assign flush   = ~RoBMC_pre_judge;
  assign if_req  = IFMC_en & ~flush;
  // LSB wins a tie unless it was granted last
  assign lsb_win = LSBMC_en & (~if_req | ~last_q);
  assign byte_a  = addr_q + ADDR_WIDTH'(cnt_q);
  assign bidx    = 2'(cnt_q - 3'd1);
  assign wr_byte = data_q[{cnt_q[1:0], 3'b000} +: 8];

`ifdef MC_IO_STALL_EN
  assign io_stall = (byte_a[17:16] == IO_SEL) & io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign io_stall  = 1'b0;
`endif

  // mem_din holds the byte addressed in the previous cycle
  always_comb begin
    buf_m = buf_q;
    buf_m[{bidx, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b0;
      cur_q       <= 1'b0;
      addr_q      <= '0;
      width_q     <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      buf_q       <= '0;
      mcif_en_q   <= 1'b0;
      mcif_data_q <= '0;
      r_en_q      <= 1'b0;
      w_en_q      <= 1'b0;
      lsb_data_q  <= '0;
      mem_a_q     <= '0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_n;
      last_q      <= last_n;
      cur_q       <= cur_n;
      addr_q      <= addr_n;
      width_q     <= width_n;
      cnt_q       <= cnt_n;
      data_q      <= data_n;
      buf_q       <= buf_n;
      mcif_en_q   <= mcif_en_n;
      mcif_data_q <= mcif_data_n;
      r_en_q      <= r_en_n;
      w_en_q      <= w_en_n;
      lsb_data_q  <= lsb_data_n;
      mem_a_q     <= mem_a_n;
      dout_q      <= dout_n;
      wr_q        <= wr_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    last_n      = last_q;
    cur_n       = cur_q;
    addr_n      = addr_q;
    width_n     = width_q;
    cnt_n       = cnt_q;
    data_n      = data_q;
    buf_n       = buf_q;
    mcif_en_n   = mcif_en_q;
    mcif_data_n = mcif_data_q;
    r_en_n      = r_en_q;
    w_en_n      = w_en_q;
    lsb_data_n  = lsb_data_q;
    mem_a_n     = mem_a_q;
    dout_n      = dout_q;
    wr_n        = wr_q;
    if (Sys_rdy) begin
      mcif_en_n = 1'b0;
      r_en_n    = 1'b0;
      w_en_n    = 1'b0;
      wr_n      = 1'b0;
      mem_a_n   = '0;
      unique case (state_q)
        IDLE: begin
          if (lsb_win) begin
            state_n = LSBMC_wr ? WRITE : READ;
            last_n  = 1'b1;
            cur_n   = 1'b1;
            addr_n  = LSBMC_addr;
            width_n = LSBMC_data_width;
            data_n  = LSBMC_data;
            cnt_n   = '0;
            buf_n   = '0;
          end else if (if_req) begin
            state_n = READ;
            last_n  = 1'b0;
            cur_n   = 1'b0;
            addr_n  = IFMC_addr;
            width_n = 3'd4;
            data_n  = '0;
            cnt_n   = '0;
            buf_n   = '0;
          end
        end
        READ: begin
          if (flush && !cur_q) begin
            // mispredicted fetch is dropped silently
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            if (cnt_q != 3'd0) buf_n = buf_m;
            if (cnt_q < width_q) begin
              mem_a_n = byte_a;
              cnt_n   = cnt_q + 3'd1;
            end else begin
              state_n = IDLE;
              cnt_n   = '0;
              if (cur_q) begin
                r_en_n     = 1'b1;
                lsb_data_n = buf_m;
              end else begin
                mcif_en_n   = 1'b1;
                mcif_data_n = buf_m;
              end
            end
          end
        end
        WRITE: begin
          if (cnt_q < width_q) begin
            if (!io_stall) begin
              wr_n    = 1'b1;
              mem_a_n = byte_a;
              dout_n  = wr_byte;
              cnt_n   = cnt_q + 3'd1;
            end
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
            w_en_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign MCIF_en    = mcif_en_q;
  assign MCIF_data  = mcif_data_q;
  assign MCLSB_r_en = r_en_q;
  assign MCLSB_w_en = w_en_q;
  assign MCLSB_data = lsb_data_q;
  assign mem_a      = mem_a_q;
  assign mem_dout   = dout_q;
  // a frozen cycle must not repeat the pending byte write
  assign mem_wr     = wr_q & Sys_rdy;

endmodule
